mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Sits between the core's load/store stage and the word-wide data memory.
- The data memory has only word access: no byte enables, combinational read data while its read strobe is high, and a registered response one cycle after each strobe.
- This block turns byte, halfword and word loads/stores into memory transactions. Sub-word stores use read-modify-write.
- It also sign/zero-extends loads, flags misaligned accesses and times out hung transactions.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles a memory strobe is held waiting for response before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- cpu_read  input  1  load request, sampled in IDLE
- cpu_write  input  1  store request, sampled in IDLE; wins over cpu_read if both high
- cpu_address  input  32  byte address
- cpu_write_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- cpu_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
- cpu_unsigned  input  1  1 = zero-extend load, 0 = sign-extend
- cpu_read_data  output  32  extended load result
- cpu_response  output  1  one-cycle completion pulse
- cpu_misaligned  output  1  valid with cpu_response; access was misaligned
- cpu_timeout  output  1  valid with cpu_response; memory did not respond
- memory_read  output  1  memory read strobe
- memory_write  output  1  memory write strobe
- address  output  32  word-aligned address, bits [1:0] = 0
- write_data  output  32  full word to write
- read_data  input  32  memory read data, valid while memory_read high
- response  input  1  memory completion, one cycle after strobe

Behaviour:
- Reset (async): state IDLE; all outputs 0, including cpu_read_data; timeout counter 0.
- Request capture in IDLE:
  - Latch address, data, size, unsigned and operation.
  - Requests outside IDLE are ignored; the core must hold them until cpu_response.
- Misalignment:
  - half with addr[0]=1, or word with addr[1:0]!=0.
  - Go to DONE with no memory strobe.
  - cpu_response=1 and cpu_misaligned=1 in the next cycle (latency 1).
- States: IDLE, RD, RMW_RD, RMW_WR, WR, WAIT_W, DONE.
- Load, accepted in cycle T:
  - RD during T+1 and T+2: memory_read=1, held until response is seen.
  - In the response cycle: select the lane (little-endian, byte at addr[1:0], half at addr[1]), extend, and register into cpu_read_data.
  - DONE at T+3: cpu_response=1. Nominal latency 3.
- Word store:
  - WR at T+1: memory_write=1 with write_data=cpu_write_data for exactly one cycle.
  - WAIT_W until response, then DONE. Nominal latency 3.
- Sub-word store:
  - RMW_RD as for a load.
  - Merge the store lane into the sampled word, leaving other lanes unchanged.
  - RMW_WR: one-cycle memory_write with the merged word.
  - WAIT_W, then DONE. Nominal latency 5.
- Strobe and address rules:
  - memory_read and memory_write are never high together.
  - address is stable from strobe assertion to response.
- Timeout:
  - Counter increments each cycle in RD, RMW_RD or WAIT_W without response.
  - On reaching TIMEOUT_CYCLES: drop strobes, go to DONE with cpu_timeout=1; cpu_read_data unchanged; an RMW store performs no write.
- cpu_read_data is updated only by successful loads; stores and errors leave it unchanged.
- DONE lasts one cycle, then IDLE. A new request may be accepted in the cycle after DONE (back-to-back throughput).
- A response received in IDLE or DONE (stale, e.g. after reset mid-transaction) is ignored.
- Reset mid-operation: immediate return to IDLE; strobes drop asynchronously; no cpu_response is produced.

Test Plan:
- Word 0x10 = 0x8899AABB; lb 0x13 -> cpu_read_data 0xFFFFFF88 at T+3; lbu 0x13 -> 0x00000088; lh 0x12 -> 0xFFFF8899; lw 0x10 -> 0x8899AABB.
- sb 0x5A at 0x11 on 0x8899AABB -> one read then one write of 0x88995ABB; cpu_response at T+5; subsequent lw 0x10 returns 0x88995ABB.
- sh 0x1234 at 0x11 and lw at 0x12 -> cpu_response+cpu_misaligned at T+1; memory_read/memory_write never asserted; memory unchanged.
- Memory model withholding response, TIMEOUT_CYCLES=4, load at 0x20 -> memory_read high exactly 4 cycles, then cpu_timeout=1 pulse, cpu_read_data unchanged.
- cpu_read=cpu_write=1, sw 0xDEADBEEF at 0x30 -> only a write occurs; lw 0x30 then returns 0xDEADBEEF; back-to-back lw accepted the cycle after DONE.
- rst asserted during RMW_RD of sb at 0x11 -> outputs 0 immediately, no write issued, word unchanged, no cpu_response.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Bus bundle between the load/store stage, the mem_access_unit and the data memory.
//
// Purpose: groups the core-side request/response signals and the word-wide memory
// strobe/response signals so the unit and its environment share one port.
//
// Modports:
//   slave  - the mem_access_unit: takes core requests and memory data/response,
//            drives the core result and the memory strobes/address/write data.
//   master - the environment (core + data memory): the mirror image of slave.
interface mem_access_unit_if;
    // core side
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_address;
    logic [31:0] cpu_write_data;
    logic [1:0]  cpu_size;
    logic        cpu_unsigned;
    logic [31:0] cpu_read_data;
    logic        cpu_response;
    logic        cpu_misaligned;
    logic        cpu_timeout;
    // memory side
    logic        memory_read;
    logic        memory_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        response;

    modport slave (
        input  cpu_read, cpu_write, cpu_address, cpu_write_data, cpu_size, cpu_unsigned,
        output cpu_read_data, cpu_response, cpu_misaligned, cpu_timeout,
        output memory_read, memory_write, address, write_data,
        input  read_data, response
    );

    modport master (
        output cpu_read, cpu_write, cpu_address, cpu_write_data, cpu_size, cpu_unsigned,
        input  cpu_read_data, cpu_response, cpu_misaligned, cpu_timeout,
        input  memory_read, memory_write, address, write_data,
        output read_data, response
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: converts byte/halfword/word loads and stores from the core into
// word-only data memory transactions.
//
// Sub-word stores are done as read-modify-write, loads are lane-selected and
// sign/zero-extended, misaligned accesses complete immediately with an error flag,
// and a strobe held too long without a memory response is aborted.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - mem_access_unit_if.slave: core request/result and memory strobe/response
// Parameter:
//   TIMEOUT_CYCLES - cycles a strobe may wait for a response before abort (0 = never)
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_unit_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, WAIT_W, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] cpu_read_data_q, cpu_read_data_d;
    logic        cpu_response_q, cpu_response_d;
    logic        cpu_misaligned_q, cpu_misaligned_d;
    logic        cpu_timeout_q, cpu_timeout_d;
    logic        memory_read_q, memory_read_d;
    logic        memory_write_q, memory_write_d;
    logic [31:0] address_q, address_d;
    logic [31:0] write_data_q, write_data_d;

    logic        req_misaligned;
    logic        timer_expire;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    logic [31:0] store_lanes;
    logic [31:0] merged_word;
    logic [3:0]  lane_we;

    // Store data replicated into every lane it could land in; the per-lane
    // enables below pick which lanes replace the word read back from memory.
    assign store_lanes = size_q[0] ? {2{data_q[15:0]}} : {4{data_q[7:0]}};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_we[gi] = size_q[0] ? (addr_q[1] == LANE[1]) : (addr_q[1:0] == LANE);
            assign merged_word[gi*8 +: 8] = lane_we[gi] ? store_lanes[gi*8 +: 8]
                                                        : bus.read_data[gi*8 +: 8];
        end
    endgenerate

    assign req_misaligned = ((bus.cpu_size == 2'b01) && bus.cpu_address[0]) ||
                            (bus.cpu_size[1] && (bus.cpu_address[1:0] != 2'b00));

    // The increment that would reach the limit is the one that aborts.
    assign timer_expire = (TIMEOUT_CYCLES != 0) && ((timer_q + 32'd1) >= TIMEOUT_CYCLES);

    // Little-endian lane select and extension of the load result.
    always_comb begin
        load_byte = 8'(bus.read_data >> {addr_q[1:0], 3'b000});
        load_half = 16'(bus.read_data >> {addr_q[1], 4'b0000});
        case (size_q)
            2'b00:   load_ext = unsigned_q ? {24'h0, load_byte} : {{24{load_byte[7]}}, load_byte};
            2'b01:   load_ext = unsigned_q ? {16'h0, load_half} : {{16{load_half[15]}}, load_half};
            default: load_ext = bus.read_data;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        data_d           = data_q;
        size_d           = size_q;
        unsigned_d       = unsigned_q;
        timer_d          = timer_q;
        cpu_read_data_d  = cpu_read_data_q;
        cpu_misaligned_d = 1'b0;
        cpu_timeout_d    = 1'b0;
        address_d        = address_q;
        write_data_d     = write_data_q;

        case (state_q)
            IDLE: begin
                timer_d = 32'd0;
                if (bus.cpu_write || bus.cpu_read) begin
                    addr_d     = bus.cpu_address;
                    data_d     = bus.cpu_write_data;
                    size_d     = bus.cpu_size;
                    unsigned_d = bus.cpu_unsigned;
                    address_d  = {bus.cpu_address[31:2], 2'b00};
                    if (req_misaligned) begin
                        state_d          = DONE;
                        cpu_misaligned_d = 1'b1;
                    end else if (bus.cpu_write) begin
                        if (bus.cpu_size[1]) begin
                            state_d      = WR;
                            write_data_d = bus.cpu_write_data;
                        end else begin
                            state_d = RMW_RD;
                        end
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD, RMW_RD, WAIT_W: begin
                if (bus.response) begin
                    timer_d = 32'd0;
                    if (state_q == RD) begin
                        cpu_read_data_d = load_ext;
                        state_d         = DONE;
                    end else if (state_q == RMW_RD) begin
                        write_data_d = merged_word;
                        state_d      = RMW_WR;
                    end else begin
                        state_d = DONE;
                    end
                end else if (timer_expire) begin
                    timer_d       = 32'd0;
                    cpu_timeout_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            RMW_WR, WR: state_d = WAIT_W;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase

        // Strobes and the completion pulse are registered from the next state so
        // they line up exactly with the state they belong to.
        cpu_response_d = (state_d == DONE);
        memory_read_d  = (state_d == RD) || (state_d == RMW_RD);
        memory_write_d = (state_d == WR) || (state_d == RMW_WR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            addr_q           <= 32'd0;
            data_q           <= 32'd0;
            size_q           <= 2'b00;
            unsigned_q       <= 1'b0;
            timer_q          <= 32'd0;
            cpu_read_data_q  <= 32'd0;
            cpu_response_q   <= 1'b0;
            cpu_misaligned_q <= 1'b0;
            cpu_timeout_q    <= 1'b0;
            memory_read_q    <= 1'b0;
            memory_write_q   <= 1'b0;
            address_q        <= 32'd0;
            write_data_q     <= 32'd0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            data_q           <= data_d;
            size_q           <= size_d;
            unsigned_q       <= unsigned_d;
            timer_q          <= timer_d;
            cpu_read_data_q  <= cpu_read_data_d;
            cpu_response_q   <= cpu_response_d;
            cpu_misaligned_q <= cpu_misaligned_d;
            cpu_timeout_q    <= cpu_timeout_d;
            memory_read_q    <= memory_read_d;
            memory_write_q   <= memory_write_d;
            address_q        <= address_d;
            write_data_q     <= write_data_d;
        end
    end

    assign bus.cpu_read_data  = cpu_read_data_q;
    assign bus.cpu_response   = cpu_response_q;
    assign bus.cpu_misaligned = cpu_misaligned_q;
    assign bus.cpu_timeout    = cpu_timeout_q;
    assign bus.memory_read    = memory_read_q;
    assign bus.memory_write   = memory_write_q;
    assign bus.address        = address_q;
    assign bus.write_data     = write_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed vector table, timeout and reset
// sequences, then random loads/stores checked against a byte-addressed model.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_unit_if bus();

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- word memory (the DUT's environment) ----------------
    logic [31:0] mem_w [0:63];
    logic        withhold;
    logic        init_mem;

    // ---------------- reference model: byte-addressed memory ----------------
    logic [7:0]  ref_b [0:255];
    logic [31:0] ref_rd;

    int n_vec = 0;
    int n_miss = 0;

    assign bus.read_data = bus.memory_read ? mem_w[bus.address[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            bus.response <= 1'b0;
            if (init_mem)
                for (int i = 0; i < 64; i++)
                    mem_w[i] <= {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
        end else begin
            bus.response <= (bus.memory_read || bus.memory_write) && !withhold;
            if (bus.memory_write)
                mem_w[bus.address[7:2]] <= bus.write_data;
        end
    end

    // ---------------- bus monitor (free-running counters) ----------------
    int rd_starts = 0, wr_starts = 0, rd_cycles = 0;
    int both_err = 0, align_err = 0, stab_err = 0;
    logic [31:0] last_wdata = 32'h0;
    logic        prev_rd = 1'b0, prev_wr = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    always @(negedge clk) begin
        if (bus.memory_read && !prev_rd) rd_starts++;
        if (bus.memory_read) rd_cycles++;
        if (bus.memory_write && !prev_wr) begin
            wr_starts++;
            last_wdata = bus.write_data;
        end
        if (bus.memory_read && bus.memory_write) both_err++;
        if ((bus.memory_read || bus.memory_write) && bus.address[1:0] != 2'b00) align_err++;
        if ((bus.memory_read || bus.memory_write) && (prev_rd || prev_wr) && bus.address != prev_addr)
            stab_err++;
        prev_rd   = bus.memory_read;
        prev_wr   = bus.memory_write;
        prev_addr = bus.address;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit ref_misaligned(input logic [31:0] a, input logic [1:0] sz);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input bit u);
        longint v = 0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) v = v + (longint'(ref_b[int'(a) + i]) << (8 * i));
        if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        for (int i = 0; i < nbytes(sz); i++) ref_b[int'(a) + i] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
    endfunction

    int txn = 0;

    // One core transaction; latency counts cycles from acceptance to cpu_response.
    task automatic run_op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input bit u,
                          output logic [31:0] rdata, output int lat, output bit mis, output bit tmo,
                          output int rds, output int wrs, output int rdc);
        int rs0, ws0, rc0;
        @(negedge clk);
        rs0 = rd_starts; ws0 = wr_starts; rc0 = rd_cycles;
        bus.cpu_write = w; bus.cpu_read = r; bus.cpu_address = a;
        bus.cpu_write_data = d; bus.cpu_size = sz; bus.cpu_unsigned = u;
        @(posedge clk);
        #1;
        bus.cpu_write = 1'b0; bus.cpu_read = 1'b0;
        lat = 0; mis = 1'b0; tmo = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.cpu_response) begin
                lat = i; mis = bus.cpu_misaligned; tmo = bus.cpu_timeout;
                break;
            end
        end
        rdata = bus.cpu_read_data;
        rds = rd_starts - rs0; wrs = wr_starts - ws0; rdc = rd_cycles - rc0;
        txn++;
        $display("txn %0d: w=%0b r=%0b addr=%h size=%0d u=%0b data=%h -> rdata=%h lat=%0d mis=%0b tmo=%0b rd=%0d wr=%0d",
                 txn, w, r, a, sz, u, d, rdata, lat, mis, tmo, rds, wrs);
    endtask

    typedef struct {
        bit          w;
        bit          r;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  sz;
        bit          u;
        logic [31:0] exp_rd;
        int          exp_lat;
        bit          exp_mis;
        int          exp_rds;
        int          exp_wrs;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [31:0] rdata, w0;
        int lat, rds, wrs, rdc, resp_seen, ws0;
        bit mis, tmo;

        tbl[0]  = '{1'b0, 1'b1, 32'h13, 32'h0,        2'd0, 1'b0, 32'hFFFFFF88, 3, 1'b0, 1, 0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 32'h13, 32'h0,        2'd0, 1'b1, 32'h00000088, 3, 1'b0, 1, 0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 32'h12, 32'h0,        2'd1, 1'b0, 32'hFFFF8899, 3, 1'b0, 1, 0, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 32'h10, 32'h0,        2'd2, 1'b0, 32'h8899AABB, 3, 1'b0, 1, 0, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 32'h11, 32'h5A,       2'd0, 1'b0, 32'h8899AABB, 5, 1'b0, 1, 1, 32'h88995ABB};
        tbl[5]  = '{1'b0, 1'b1, 32'h10, 32'h0,        2'd2, 1'b0, 32'h88995ABB, 3, 1'b0, 1, 0, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 32'h11, 32'h1234,     2'd1, 1'b0, 32'h88995ABB, 1, 1'b1, 0, 0, 32'h0};
        tbl[7]  = '{1'b0, 1'b1, 32'h12, 32'h0,        2'd2, 1'b0, 32'h88995ABB, 1, 1'b1, 0, 0, 32'h0};
        tbl[8]  = '{1'b1, 1'b1, 32'h30, 32'hDEADBEEF, 2'd2, 1'b0, 32'h88995ABB, 3, 1'b0, 0, 1, 32'hDEADBEEF};
        tbl[9]  = '{1'b0, 1'b1, 32'h30, 32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 3, 1'b0, 1, 0, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 32'h32, 32'h0,        2'd1, 1'b1, 32'h0000DEAD, 3, 1'b0, 1, 0, 32'h0};
        tbl[11] = '{1'b0, 1'b1, 32'h30, 32'h0,        2'd1, 1'b0, 32'hFFFFBEEF, 3, 1'b0, 1, 0, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 32'h32, 32'hFFFF8001, 2'd1, 1'b0, 32'hFFFFBEEF, 5, 1'b0, 1, 1, 32'h8001BEEF};
        tbl[13] = '{1'b0, 1'b1, 32'h30, 32'h0,        2'd3, 1'b0, 32'h8001BEEF, 3, 1'b0, 1, 0, 32'h0};
        tbl[14] = '{1'b0, 1'b1, 32'h31, 32'h0,        2'd0, 1'b1, 32'h000000BE, 3, 1'b0, 1, 0, 32'h0};
        tbl[15] = '{1'b1, 1'b0, 32'h33, 32'h1237F,    2'd0, 1'b0, 32'h000000BE, 5, 1'b0, 1, 1, 32'h7F01BEEF};
        tbl[16] = '{1'b0, 1'b1, 32'h31, 32'h0,        2'd3, 1'b0, 32'h000000BE, 1, 1'b1, 0, 0, 32'h0};

        // memory contents: random, with the known word at 0x10
        for (int i = 0; i < 256; i++) ref_b[i] = 8'($urandom);
        ref_store(32'h10, 32'h8899AABB, 2'd2);
        ref_rd = 32'h0;

        withhold = 1'b0;
        init_mem = 1'b1;
        bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_address = 32'h0;
        bus.cpu_write_data = 32'h0; bus.cpu_size = 2'd0; bus.cpu_unsigned = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        init_mem = 1'b0;
        @(negedge clk);

        chk("reset cpu_read_data", bus.cpu_read_data, 32'h0);
        chk("reset address", bus.address, 32'h0);
        chk("reset write_data", bus.write_data, 32'h0);
        chk("reset flags", 32'({bus.cpu_response, bus.cpu_misaligned, bus.cpu_timeout,
                                bus.memory_read, bus.memory_write}), 32'h0);

        // ---------------- directed table ----------------
        for (int k = 0; k < 17; k++) begin
            run_op(tbl[k].w, tbl[k].r, tbl[k].a, tbl[k].d, tbl[k].sz, tbl[k].u,
                   rdata, lat, mis, tmo, rds, wrs, rdc);
            chk($sformatf("tbl%0d rdata", k), rdata, tbl[k].exp_rd);
            chk($sformatf("tbl%0d latency", k), 32'(lat), 32'(tbl[k].exp_lat));
            chk($sformatf("tbl%0d misaligned", k), 32'(mis), 32'(tbl[k].exp_mis));
            chk($sformatf("tbl%0d timeout", k), 32'(tmo), 32'h0);
            chk($sformatf("tbl%0d read strobes", k), 32'(rds), 32'(tbl[k].exp_rds));
            chk($sformatf("tbl%0d write strobes", k), 32'(wrs), 32'(tbl[k].exp_wrs));
            if (tbl[k].exp_wrs != 0)
                chk($sformatf("tbl%0d write word", k), last_wdata, tbl[k].exp_wdata);
            if (tbl[k].w && !tbl[k].exp_mis) ref_store(tbl[k].a, tbl[k].d, tbl[k].sz);
            ref_rd = tbl[k].exp_rd;
        end
        chk("mem word 0x10", mem_w[4], 32'h88995ABB);
        chk("mem word 0x30", mem_w[12], 32'h7F01BEEF);

        // ---------------- timeout: memory withholds response ----------------
        withhold = 1'b1;
        run_op(1'b0, 1'b1, 32'h20, 32'h0, 2'd2, 1'b0, rdata, lat, mis, tmo, rds, wrs, rdc);
        chk("tmo load latency", 32'(lat), 32'd5);
        chk("tmo load flag", 32'(tmo), 32'h1);
        chk("tmo load read cycles", 32'(rdc), 32'd4);
        chk("tmo load rdata kept", rdata, ref_rd);
        run_op(1'b1, 1'b0, 32'h21, 32'h55, 2'd0, 1'b0, rdata, lat, mis, tmo, rds, wrs, rdc);
        chk("tmo sb latency", 32'(lat), 32'd5);
        chk("tmo sb flag", 32'(tmo), 32'h1);
        chk("tmo sb no write", 32'(wrs), 32'd0);
        withhold = 1'b0;
        chk("tmo sb mem kept", mem_w[8], ref_word(8));

        // ---------------- reset during RMW_RD ----------------
        @(negedge clk);
        ws0 = wr_starts;
        bus.cpu_write = 1'b1; bus.cpu_address = 32'h11; bus.cpu_write_data = 32'hA5;
        bus.cpu_size = 2'd0;
        @(posedge clk);
        #1;
        bus.cpu_write = 1'b0;
        @(negedge clk);
        chk("rmw strobe before reset", 32'(bus.memory_read), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("reset drops strobes", 32'({bus.memory_read, bus.memory_write, bus.cpu_response}), 32'h0);
        chk("reset clears read data", bus.cpu_read_data, 32'h0);
        chk("reset clears address", bus.address, 32'h0);
        ref_rd = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        resp_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.cpu_response) resp_seen++;
        end
        txn++;
        $display("txn %0d: reset during RMW_RD of sb @0x11 -> responses=%0d writes=%0d",
                 txn, resp_seen, wr_starts - ws0);
        chk("no response after reset", 32'(resp_seen), 32'd0);
        chk("no write after reset", 32'(wr_starts - ws0), 32'd0);
        chk("word unchanged after reset", mem_w[4], ref_word(4));

        // ---------------- random against byte model ----------------
        for (int k = 0; k < 80; k++) begin
            logic [31:0] a, d, exp_rd;
            logic [1:0]  sz;
            bit u, ew, er, emis;
            int kind, elat, erds, ewrs;
            a = 32'($urandom_range(64, 255));
            d = $urandom;
            sz = 2'($urandom_range(0, 3));
            u = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 2);
            ew = (kind != 0);
            er = (kind != 1);
            emis = ref_misaligned(a, sz);
            if (emis) begin
                elat = 1; erds = 0; ewrs = 0;
            end else if (!ew) begin
                elat = 3; erds = 1; ewrs = 0;
                ref_rd = ref_load(a, sz, u);
            end else if (sz >= 2'd2) begin
                elat = 3; erds = 0; ewrs = 1;
            end else begin
                elat = 5; erds = 1; ewrs = 1;
            end
            if (ew && !emis) ref_store(a, d, sz);
            exp_rd = ref_rd;
            run_op(ew, er, a, d, sz, u, rdata, lat, mis, tmo, rds, wrs, rdc);
            chk($sformatf("rnd%0d rdata", k), rdata, exp_rd);
            chk($sformatf("rnd%0d latency", k), 32'(lat), 32'(elat));
            chk($sformatf("rnd%0d misaligned", k), 32'(mis), 32'(emis));
            chk($sformatf("rnd%0d timeout", k), 32'(tmo), 32'h0);
            chk($sformatf("rnd%0d read strobes", k), 32'(rds), 32'(erds));
            chk($sformatf("rnd%0d write strobes", k), 32'(wrs), 32'(ewrs));
            if (ewrs != 0) begin
                w0 = ref_word(int'(a) / 4);
                chk($sformatf("rnd%0d write word", k), last_wdata, w0);
            end
        end
        for (int i = 16; i < 64; i++)
            chk($sformatf("final mem word %0d", i), mem_w[i], ref_word(i));

        chk("read/write strobe overlap", 32'(both_err), 32'd0);
        chk("unaligned memory address", 32'(align_err), 32'd0);
        chk("address unstable under strobe", 32'(stab_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
